modexp_unit: RTL

- Parametrised successor to the fixed 8-bit RSA datapath: computes C = X^E mod N over WIDTH-bit operands.
- Uses Montgomery arithmetic with a start/busy/done handshake, operand validation and fixed, data-independent latency.
- Contains its own two bit-serial Montgomery multipliers: a multiply lane and a square lane, running in parallel, right-to-left binary exponentiation.
- Sits between the host register interface and the crypto result register; the host supplies the precomputed Montgomery constant.

---
 rtl/modexp_unit_if.sv | 19 +
 rtl/modexp_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/modexp_unit_if.sv
// Host-side handshake and operand bus for the modular exponentiation unit.
// The host drives operands and start; the unit returns busy/done/err and the result.
interface modexp_unit_if #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     x;
  logic [EXP_WIDTH-1:0] e;
  logic [WIDTH-1:0]     n;
  logic [WIDTH-1:0]     rconst;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [WIDTH-1:0]     c;

  modport master (output start, x, e, n, rconst, input busy, done, err, c);
  modport slave  (input start, x, e, n, rconst, output busy, done, err, c);
endinterface

// File: rtl/modexp_unit.sv
// C = X^E mod N using two parallel bit-serial Montgomery lanes (square and multiply),
// right-to-left binary exponentiation with fixed latency (EXP_WIDTH+2)*(WIDTH+3) cycles.
module modexp_unit #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rstb,
  modexp_unit_if.slave  io
);
  localparam int K  = WIDTH + 2;
  localparam int CW = $clog2(K + 1);
  localparam int RW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(K);
  localparam logic [RW-1:0] ROUND_LAST = RW'(EXP_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_LOOP  = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // One add/halve iteration: acc' = (acc + a*B + q*N) / 2, sum held in K+1 bits.
  function automatic logic [K-1:0] f_mont_step(input logic [K-1:0] acc, input logic a_bit,
                                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] m);
    logic [K:0] sum;
    sum = {1'b0, acc} + (a_bit ? {3'b000, b} : {(K+1){1'b0}});
    if (sum[0]) begin
      sum = sum + {3'b000, m};
    end else begin
      sum = sum;
    end
    return sum[K:1];
  endfunction

  // Accumulator is below 2N, so one conditional subtract fully reduces it.
  function automatic logic [WIDTH-1:0] f_reduce(input logic [K-1:0] acc, input logic [WIDTH-1:0] m);
    logic [K-1:0] diff;
    diff = acc - {2'b00, m};
    return (acc >= {2'b00, m}) ? diff[WIDTH-1:0] : acc[WIDTH-1:0];
  endfunction

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_n, r_p, r_r, r_b_sq, r_b_mu, r_c;
  logic [K-1:0]         r_acc_sq, r_acc_mu, r_sh_sq, r_sh_mu;
  logic [EXP_WIDTH-1:0] r_e;
  logic [CW-1:0]        r_cnt;
  logic [RW-1:0]        r_round;
  logic                 r_mu_en, r_busy, r_done, r_err;
  logic                 w_accept, w_invalid, w_computing, w_round_end, w_last_loop;
  logic                 w_mu_en_next;
  logic [WIDTH-1:0]     w_p_new, w_r_new, w_b_mu_next;

  assign w_accept    = (r_state == S_IDLE) && io.start;
  assign w_invalid   = ~io.n[0] || (io.n < WIDTH'(3)) || (io.x >= io.n) || (io.rconst >= io.n);
  assign w_computing = (r_state == S_INIT) || (r_state == S_LOOP) || (r_state == S_FINAL);
  assign w_round_end = w_computing && (r_cnt == CNT_LAST);
  assign w_last_loop = (r_state == S_LOOP) && (r_round == ROUND_LAST);
  assign w_p_new     = f_reduce(r_acc_sq, r_n);
  assign w_r_new     = r_mu_en ? f_reduce(r_acc_mu, r_n) : r_r;

  // Operands of the multiply lane for the round that follows the current one.
  always_comb begin
    w_b_mu_next  = w_p_new;
    w_mu_en_next = r_e[0];
    if (w_last_loop) begin
      w_b_mu_next  = WIDTH'(1);
      w_mu_en_next = 1'b1;
    end else begin
      w_b_mu_next  = w_p_new;
      w_mu_en_next = r_e[0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (io.start) begin
          w_next = w_invalid ? S_ERR : S_INIT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_INIT:  w_next = w_round_end ? S_LOOP : S_INIT;
      S_LOOP:  w_next = (w_round_end && (r_round == ROUND_LAST)) ? S_FINAL : S_LOOP;
      S_FINAL: w_next = w_round_end ? S_DONE : S_FINAL;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath; the acceptance edge already performs the first INIT iteration from the raw inputs.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_n      <= {WIDTH{1'b0}};
      r_p      <= {WIDTH{1'b0}};
      r_r      <= {WIDTH{1'b0}};
      r_b_sq   <= {WIDTH{1'b0}};
      r_b_mu   <= {WIDTH{1'b0}};
      r_c      <= {WIDTH{1'b0}};
      r_acc_sq <= {K{1'b0}};
      r_acc_mu <= {K{1'b0}};
      r_sh_sq  <= {K{1'b0}};
      r_sh_mu  <= {K{1'b0}};
      r_e      <= {EXP_WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_round  <= {RW{1'b0}};
      r_mu_en  <= 1'b0;
    end else if (w_accept) begin
      r_n      <= io.n;
      r_e      <= io.e;
      r_acc_sq <= f_mont_step({K{1'b0}}, io.rconst[0], io.x, io.n);
      r_acc_mu <= f_mont_step({K{1'b0}}, io.rconst[0], WIDTH'(1), io.n);
      r_sh_sq  <= {3'b000, io.rconst[WIDTH-1:1]};
      r_sh_mu  <= {3'b000, io.rconst[WIDTH-1:1]};
      r_b_sq   <= io.x;
      r_b_mu   <= WIDTH'(1);
      r_mu_en  <= 1'b1;
      r_cnt    <= CW'(1);
      r_round  <= {RW{1'b0}};
    end else if (w_round_end) begin
      r_p      <= w_p_new;
      r_r      <= w_r_new;
      r_acc_sq <= {K{1'b0}};
      r_acc_mu <= {K{1'b0}};
      r_sh_sq  <= {2'b00, w_p_new};
      r_sh_mu  <= {2'b00, w_r_new};
      r_b_sq   <= w_p_new;
      r_b_mu   <= w_b_mu_next;
      r_mu_en  <= w_mu_en_next;
      r_e      <= r_e >> 1;
      r_cnt    <= {CW{1'b0}};
      r_round  <= (r_state == S_INIT) ? {RW{1'b0}} : r_round + RW'(1);
      if (r_state == S_FINAL) begin
        r_c <= w_r_new;
      end
    end else if (w_computing) begin
      r_acc_sq <= f_mont_step(r_acc_sq, r_sh_sq[0], r_b_sq, r_n);
      r_sh_sq  <= r_sh_sq >> 1;
      if (r_mu_en) begin
        r_acc_mu <= f_mont_step(r_acc_mu, r_sh_mu[0], r_b_mu, r_n);
        r_sh_mu  <= r_sh_mu >> 1;
      end
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Handshake outputs, registered from the upcoming state.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (w_next == S_INIT) || (w_next == S_LOOP) || (w_next == S_FINAL);
      r_done <= (w_next == S_DONE) || (w_next == S_ERR);
      if (w_accept) begin
        r_err <= w_invalid;
      end
    end
  end

  assign io.busy = r_busy;
  assign io.done = r_done;
  assign io.err  = r_err;
  assign io.c    = r_c;
endmodule
